vai_audit_tx: RTL
=================

// Module: vai_audit_tx
// PURPOSE
// Per-sub-AFU Tx auditor sitting between a sub-AFU and the VAI mux, downstream of the VAI manager.
// Relocates c0/c1 request addresses by the manager-programmed offset and drops requests whose
// relocation overflows. Tracks outstanding reads/writes and runs the per-AFU soft-reset drain
// sequence: sub-AFU reset is released to the AFU only after its in-flight traffic has retired.
// PARAMETERS
// OUTS_W     10  width of outstanding-request counters (max 2^OUTS_W-1 in flight per channel)
// VIOL_W     16  width of the saturating violation counter
// PORTS
// clk              in   1       CCI-P primary clock (pClk)
// reset            in   1       async, active-high
// offset           in   64      relocation offset for this AFU (manager offset_array[vmid]); [41:0] used
// reset_req        in   1       this AFU's bit of manager sub_afu_reset
// afu_c0           in   t_if_ccip_c0_Tx  read requests from sub-AFU
// afu_c1           in   t_if_ccip_c1_Tx  write/fence requests from sub-AFU
// rx_c0_rsp        in   1       c0 rspValid routed to this AFU (read data)
// rx_c1_rsp        in   1       c1 rspValid routed to this AFU
// rx_c1_hdr        in   t_ccip_c1_RspMemHdr  header of that c1 response
// mux_c0           out  t_if_ccip_c0_Tx  relocated read request to mux
// mux_c1           out  t_if_ccip_c1_Tx  relocated write request to mux
// afu_reset        out  1       reset driven into sub-AFU
// drain_busy       out  1       high in DRAIN state
// viol_cnt         out  VIOL_W  dropped-request count (overflow or issued during DRAIN/HOLD)
// outs_err         out  1       sticky: response received with counter at 0
// BEHAVIOUR
// - Reset values: mux_c0.valid=0, mux_c1.valid=0, afu_reset=1, drain_busy=0, viol_cnt=0,
//   outs_err=0, both outstanding counters=0, state=HOLD.
// - Pipeline: 2 cycles input->output. S1 registers request and computes sum=addr+offset[41:0]
//   (43-bit, carry kept); S2 registers output. No backpressure inside: almost-full is handled by
//   the sub-AFU from mux RxPort, so every valid input produces an output or a drop in S2.
// - Address: out addr = sum[41:0]; if sum[42]=1 -> valid forced 0, viol_cnt+1. All other header
//   fields and data pass unchanged. c1 fences (req_type WrFence) are not relocated, never dropped
//   for overflow.
// - offset sampled in S1 each cycle; a change takes effect for requests entering S1 next cycle.
// - Outstanding counters: c0 +1 per emitted mux_c0.valid, -1 per rx_c0_rsp. c1 +1 per emitted
//   mux_c1.valid (each beat of multi-line write, and fences), -(cl_num+1) per rx_c1_rsp when
//   rx_c1_hdr.format=1, else -1. Inc and dec same cycle -> net. Decrement below 0 -> clamp 0,
//   set outs_err. Increment at max -> hold max, set outs_err.
// - FSM states RUN, DRAIN, HOLD:
//   RUN:   forwards traffic; afu_reset=0. reset_req=1 -> DRAIN.
//   DRAIN: drop every new S1 request (viol_cnt+1 each); requests already in S2 still emit.
//          afu_reset=0, drain_busy=1. When both counters==0 and S1/S2 empty -> HOLD.
//          reset_req falling in DRAIN does not abort; drain completes, then HOLD.
//   HOLD:  afu_reset=1, drops requests; reset_req==0 -> RUN (afu_reset falls next cycle).
// - viol_cnt saturates at all-ones. Async reset mid-drain returns to HOLD with counters cleared.
// STRUCTURE
// - Package vai_audit_pkg: typedef enum logic[1:0] {RUN, DRAIN, HOLD} t_audit_state;
//   localparam CLADDR_W=42; function is_fence(t_if_ccip_c1_Tx).
// - Sub-module vai_audit_outs_cnt #(OUTS_W): saturating up/down counter (inc, dec_amt[2:0],
//   zero, err); instantiated twice (c0, c1).
// TESTING
// 1 offset=0x100, c0 read addr 0x20 -> mux_c0 addr 0x120 exactly 2 cycles later, mdata unchanged.
// 2 offset=0x3FF_FFFF_FFFF, addr 0x2 -> no mux_c0.valid, viol_cnt=1; fence on c1 same cycle passes.
// 3 issue 4 reads, reset_req=1 -> DRAIN, new reads dropped (viol_cnt counts), 4 rx_c0_rsp ->
//   HOLD next cycle, afu_reset=1; reset_req=0 -> RUN, afu_reset=0 one cycle later.
// 4 4-beat write, packed c1 rsp format=1 cl_num=3 -> c1 counter 4->0, outs_err stays 0.
// 5 rx_c0_rsp with counter 0 -> outs_err=1, counter stays 0; simultaneous req+rsp at 5 -> stays 5.
// 6 assert reset during DRAIN with 3 outstanding -> HOLD, counters 0, afu_reset=1, viol_cnt=0.

Source files
------------

// File: rtl/vai_audit_pkg.sv
// vai_audit_pkg: CCI-P Tx/Rx subset types, auditor FSM states and helpers for vai_audit_tx.
// Only the header fields the auditor touches or forwards are modelled.
package vai_audit_pkg;

    localparam int CLADDR_W = 42;

    localparam logic [3:0] REQ_RDLINE  = 4'h0;
    localparam logic [3:0] REQ_WRLINE  = 4'h0;
    localparam logic [3:0] REQ_WRFENCE = 4'h4;

    typedef enum logic [1:0] {RUN, DRAIN, HOLD} t_audit_state;

    typedef struct packed {
        logic [1:0]          cl_len;
        logic [3:0]          req_type;
        logic [CLADDR_W-1:0] address;
        logic [15:0]         mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic                sop;
        logic [1:0]          cl_len;
        logic [3:0]          req_type;
        logic [CLADDR_W-1:0] address;
        logic [15:0]         mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic       format;
        logic [1:0] cl_num;
        logic [3:0] resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_RspMemHdr;

    function automatic logic is_fence(input t_if_ccip_c1_Tx c1);
        return c1.hdr.req_type == REQ_WRFENCE;
    endfunction

endpackage

// File: rtl/vai_audit_tx_outs_cnt.sv
// vai_audit_outs_cnt: saturating outstanding-request counter.
// Ports: clk, reset (async, active-high), inc (+1), dec_amt (0..4 retired),
//        zero (count is 0), err (sticky: underflow or overflow attempted).
module vai_audit_outs_cnt #(
    parameter int OUTS_W = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic [2:0] dec_amt,
    output logic       zero,
    output logic       err
);

    logic [OUTS_W-1:0] cnt;
    logic [OUTS_W:0]   up;
    logic [OUTS_W:0]   dec;
    logic [OUTS_W:0]   diff;
    logic              under;
    logic              over;

    // Increment first in one extra bit so inc+dec in the same cycle nets out even at max.
    assign up    = {1'b0, cnt} + {{OUTS_W{1'b0}}, inc};
    assign dec   = {{(OUTS_W-2){1'b0}}, dec_amt};
    assign under = up < dec;
    assign diff  = up - dec;
    assign over  = !under && diff[OUTS_W];
    assign zero  = cnt == '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= under ? '0 : over ? '1 : diff[OUTS_W-1:0];
            err <= err | under | over;
        end
    end

endmodule

// File: rtl/vai_audit_tx.sv
// vai_audit_tx: per-sub-AFU Tx auditor: address relocation, overflow drop, outstanding tracking, soft-reset drain.
// Ports: clk, reset (async, active-high), offset (relocation, [41:0] used), reset_req (soft-reset request),
//        afu_c0/afu_c1 (requests from sub-AFU), rx_c0_rsp/rx_c1_rsp/rx_c1_hdr (responses for this AFU),
//        mux_c0/mux_c1 (relocated requests, 2-cycle latency), afu_reset (reset into sub-AFU),
//        drain_busy (draining), viol_cnt (saturating drop count), outs_err (sticky counter misuse).
module vai_audit_tx
    import vai_audit_pkg::*;
#(
    parameter int OUTS_W = 10,
    parameter int VIOL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [63:0]        offset,
    input  logic               reset_req,
    input  t_if_ccip_c0_Tx     afu_c0,
    input  t_if_ccip_c1_Tx     afu_c1,
    input  logic               rx_c0_rsp,
    input  logic               rx_c1_rsp,
    input  t_ccip_c1_RspMemHdr rx_c1_hdr,
    output t_if_ccip_c0_Tx     mux_c0,
    output t_if_ccip_c1_Tx     mux_c1,
    output logic               afu_reset,
    output logic               drain_busy,
    output logic [VIOL_W-1:0]  viol_cnt,
    output logic               outs_err
);

    t_audit_state        state, state_nxt;
    t_if_ccip_c0_Tx      s1_c0;
    t_if_ccip_c1_Tx      s1_c1;
    logic [CLADDR_W-1:0] off_q;
    logic [CLADDR_W:0]   sum0, sum1;
    logic                drop0, drop1;
    logic                fence1;
    logic [VIOL_W:0]     viol_sum;
    logic [2:0]          c1_dec;
    logic                c0_zero, c1_zero, c0_err, c1_err;
    logic                drained;
    logic                unused_ok;

    assign unused_ok = ^{offset[63:CLADDR_W], rx_c1_hdr.resp_type, rx_c1_hdr.mdata};

    // Carry bit of the 43-bit sum flags a relocation past the top of the address space.
    assign sum0   = {1'b0, s1_c0.hdr.address} + {1'b0, off_q};
    assign sum1   = {1'b0, s1_c1.hdr.address} + {1'b0, off_q};
    assign fence1 = is_fence(s1_c1);
    assign drop0  = s1_c0.valid && (state != RUN || sum0[CLADDR_W]);
    assign drop1  = s1_c1.valid && (state != RUN || (!fence1 && sum1[CLADDR_W]));

    assign viol_sum = {1'b0, viol_cnt} + {{(VIOL_W-1){1'b0}}, drop0} + {{(VIOL_W-1){1'b0}}, drop1};

    // Packed responses retire cl_num+1 lines at once.
    assign c1_dec = !rx_c1_rsp ? 3'd0 : rx_c1_hdr.format ? {1'b0, rx_c1_hdr.cl_num} + 3'd1 : 3'd1;

    assign drained = c0_zero && c1_zero && !s1_c0.valid && !s1_c1.valid && !mux_c0.valid && !mux_c1.valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_c0    <= '0;
            s1_c1    <= '0;
            off_q    <= '0;
            mux_c0   <= '0;
            mux_c1   <= '0;
            viol_cnt <= '0;
            state    <= HOLD;
        end else begin
            s1_c0                  <= afu_c0;
            s1_c1                  <= afu_c1;
            off_q                  <= offset[CLADDR_W-1:0];
            mux_c0                 <= s1_c0;
            mux_c0.hdr.address     <= sum0[CLADDR_W-1:0];
            mux_c0.valid           <= s1_c0.valid && !drop0;
            mux_c1                 <= s1_c1;
            mux_c1.hdr.address     <= fence1 ? s1_c1.hdr.address : sum1[CLADDR_W-1:0];
            mux_c1.valid           <= s1_c1.valid && !drop1;
            viol_cnt               <= viol_sum[VIOL_W] ? '1 : viol_sum[VIOL_W-1:0];
            state                  <= state_nxt;
        end
    end

    // Once draining starts it always runs to HOLD, even if reset_req drops meanwhile.
    always_comb begin
        state_nxt  = state;
        afu_reset  = state == HOLD;
        drain_busy = state == DRAIN;
        case (state)
            RUN:     if (reset_req) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = HOLD;
            HOLD:    if (!reset_req) state_nxt = RUN;
            default: state_nxt = HOLD;
        endcase
    end

    vai_audit_outs_cnt #(.OUTS_W(OUTS_W)) u_c0 (
        .clk     (clk),
        .reset   (reset),
        .inc     (mux_c0.valid),
        .dec_amt ({2'b00, rx_c0_rsp}),
        .zero    (c0_zero),
        .err     (c0_err)
    );

    vai_audit_outs_cnt #(.OUTS_W(OUTS_W)) u_c1 (
        .clk     (clk),
        .reset   (reset),
        .inc     (mux_c1.valid),
        .dec_amt (c1_dec),
        .zero    (c1_zero),
        .err     (c1_err)
    );

    assign outs_err = c0_err | c1_err;

endmodule
